// File: rtl/dlfloat_mult_pipe.sv
// Three-stage pipelined DLFloat multiplier (unpack, multiply, normalise/round/pack)
// with one global stall enable and {nv, of, uf, nx} exception flags.
module dlfloat_mult_pipe #(
   parameter int EXP_W = 6,
   parameter int MAN_W = 9,
   parameter int BIAS  = 2**(EXP_W-1)-1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   y,
   output logic [3:0]             flags
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int PW = 2 * (MAN_W + 1);
   localparam int EW = EXP_W + 2;

   logic en;

   logic [EXP_W-1:0] exp_a, exp_b;
   logic [EW-1:0]    exp_sum;

   logic             v1, s1_sign, s1_zero, s1_spec;
   logic [EW-1:0]    s1_exp;
   logic [MAN_W-1:0] s1_fa, s1_fb;

   logic             v2, s2_sign, s2_zero, s2_spec;
   logic [EW-1:0]    s2_exp;
   logic [PW-1:0]    s2_prod;

   logic             msb, guard, sticky, round_up, carry;
   logic [PW-2:0]    norm;
   logic [MAN_W-1:0] frac_t;
   logic [MAN_W:0]   frac_r;
   logic [EW-1:0]    exp_f;
   logic [W-1:0]     packed_res;
   logic [W-1:0]     y_next;
   logic [3:0]       flags_next;

   // Every stage advances together; a full output register blocks the whole pipe.
   assign en       = !out_valid | out_ready;
   assign in_ready = en;

   assign exp_a   = a[MAN_W +: EXP_W];
   assign exp_b   = b[MAN_W +: EXP_W];
   assign exp_sum = EW'(exp_a) + EW'(exp_b) - EW'(BIAS);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1      <= 1'b0;
         s1_sign <= 1'b0;
         s1_zero <= 1'b0;
         s1_spec <= 1'b0;
         s1_exp  <= '0;
         s1_fa   <= '0;
         s1_fb   <= '0;
      end else if (en) begin
         v1      <= in_valid;
         s1_sign <= a[W-1] ^ b[W-1];
         s1_zero <= (exp_a == '0) || (exp_b == '0);
         s1_spec <= (&a) || (&b);
         s1_exp  <= exp_sum;
         s1_fa   <= a[MAN_W-1:0];
         s1_fb   <= b[MAN_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2      <= 1'b0;
         s2_sign <= 1'b0;
         s2_zero <= 1'b0;
         s2_spec <= 1'b0;
         s2_exp  <= '0;
         s2_prod <= '0;
      end else if (en) begin
         v2      <= v1;
         s2_sign <= s1_sign;
         s2_zero <= s1_zero;
         s2_spec <= s1_spec;
         s2_exp  <= s1_exp;
         s2_prod <= PW'({1'b1, s1_fa}) * PW'({1'b1, s1_fb});
      end
   end

   // The product of two 1.x mantissas lies in [1,4); align so the hidden one is dropped.
   assign msb      = s2_prod[PW-1];
   assign norm     = msb ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
   assign frac_t   = norm[PW-2 -: MAN_W];
   assign guard    = norm[PW-2-MAN_W];
   assign sticky   = |norm[PW-3-MAN_W:0];
   assign round_up = guard & (sticky | frac_t[0]);
   assign frac_r   = {1'b0, frac_t} + (MAN_W+1)'(round_up);
   assign carry    = frac_r[MAN_W];
   assign exp_f    = s2_exp + EW'(msb) + EW'(carry);
   assign packed_res = {s2_sign, exp_f[EXP_W-1:0], frac_r[MAN_W-1:0]};

   // Exception priority: special operand, zero operand, underflow, overflow, normal.
   always_comb begin
      y_next     = '0;
      flags_next = 4'b0000;
      if (s2_spec) begin
         y_next     = '1;
         flags_next = 4'b1000;
      end else if (s2_zero) begin
         flags_next = 4'b0000;
      end else if (exp_f[EW-1] || (exp_f == '0)) begin
         flags_next = 4'b0011;
      end else if ((exp_f > EW'(2**EXP_W - 1)) || (&packed_res)) begin
         y_next     = '1;
         flags_next = 4'b0101;
      end else begin
         y_next     = packed_res;
         flags_next = {3'b000, guard | sticky};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         y         <= '0;
         flags     <= 4'b0000;
      end else if (en) begin
         out_valid <= v2;
         if (v2) begin
            y     <= y_next;
            flags <= flags_next;
         end
      end
   end

endmodule

// File: tb/tb_dlfloat_mult_pipe.sv
// Scoreboard bench for dlfloat_mult_pipe (DLFloat16 defaults): directed vectors,
// back-pressure stream, and asynchronous reset with operations in flight.
module tb_dlfloat_mult_pipe;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] y;
   logic [3:0]  flags;

   int n_cmp = 0;
   int n_bad = 0;
   logic [19:0] exp_q[$];
   bit bp_mode = 0;
   int bp_cnt  = 0;

   dlfloat_mult_pipe dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .flags     (flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Reference model in integer arithmetic: exact product, round by comparing remainder to half.
   function automatic logic [19:0] refModel(input logic [15:0] x, input logic [15:0] z);
      int m, e, sh, q, rem, half;
      logic nx;
      logic [15:0] r;
      if (x == 16'hFFFF || z == 16'hFFFF) return {16'hFFFF, 4'b1000};
      if (x[14:9] == 6'd0 || z[14:9] == 6'd0) return {16'h0000, 4'b0000};
      m  = (512 + int'(x[8:0])) * (512 + int'(z[8:0]));
      e  = int'(x[14:9]) + int'(z[14:9]) - 31;
      sh = (m >= (1 << 19)) ? 10 : 9;
      if (sh == 10) e++;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = 1 << (sh - 1);
      nx   = (rem != 0);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == 1024) begin
         q = 512;
         e++;
      end
      if (e <= 0) return {16'h0000, 4'b0011};
      if (e > 63) return {16'hFFFF, 4'b0101};
      r = {x[15] ^ z[15], 6'(e), 9'(q)};
      if (r == 16'hFFFF) return {16'hFFFF, 4'b0101};
      return {r, 3'b000, nx};
   endfunction

   // Called just after a rising edge; returns just after the edge that took the operands.
   task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb_op);
      bit taken = 0;
      a = ta;
      b = tb_op;
      in_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (in_ready) begin
            taken = 1;
            break;
         end
      end
      if (taken) exp_q.push_back(refModel(ta, tb_op));
      else checkOutput("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic measureLatency();
      int n = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n++;
         if (out_valid) break;
      end
      checkOutput("latency", 32'(n), 32'd3);
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      checkOutput("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // out_ready: high normally; during back-pressure toggles each cycle with one 5-cycle low hold.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode) begin
            bp_cnt++;
            out_ready = (bp_cnt >= 6 && bp_cnt <= 10) ? 1'b0 : bp_cnt[0];
         end else begin
            out_ready = 1'b1;
         end
      end
   end

   // Output monitor: handshake rule, stall stability, in-order scoreboard compare.
   initial begin
      logic        prev_stall;
      logic [15:0] prev_y;
      logic [3:0]  prev_flags;
      logic [19:0] e;
      prev_stall = 1'b0;
      prev_y     = '0;
      prev_flags = '0;
      forever begin
         @(negedge clk);
         checkOutput("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
         if (prev_stall) begin
            checkOutput("stall_valid", 32'(out_valid), 32'd1);
            checkOutput("stall_y", 32'(y), 32'(prev_y));
            checkOutput("stall_flags", 32'(flags), 32'(prev_flags));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_out", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("y", 32'(y), 32'(e[19:4]));
               checkOutput("flags", 32'(flags), 32'(e[3:0]));
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_y     = y;
         prev_flags = flags;
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [15:0] va[8] = '{16'h3E00, 16'h3E01, 16'h3E01, 16'h7C00,
                             16'h0200, 16'hFFFF, 16'hFFFF, 16'h0000};
      logic [15:0] vb[8] = '{16'hC000, 16'h3E01, 16'h3F00, 16'h7C00,
                             16'h0200, 16'h3E00, 16'h0000, 16'hBE00};
      logic [15:0] ra, rb;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      #3;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_y", 32'(y), 32'd0);
      checkOutput("rst_flags", 32'(flags), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] basic 1.5*1.5 with latency");
      applyStimulus(16'h3F00, 16'h3F00);
      measureLatency();
      waitDrain();
      @(posedge clk);
      #1;

      $display("[TB] directed vectors back-to-back");
      for (int i = 0; i < 8; i++) applyStimulus(va[i], vb[i]);
      waitDrain();

      $display("[TB] random stream under back-pressure");
      bp_mode = 1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         ra = {1'($urandom_range(0, 1)), 6'($urandom_range(1, 62)), 9'($urandom_range(0, 511))};
         rb = {1'($urandom_range(0, 1)), 6'($urandom_range(1, 62)), 9'($urandom_range(0, 511))};
         applyStimulus(ra, rb);
      end
      waitDrain();
      bp_mode = 0;
      @(posedge clk);
      #1;

      $display("[TB] asynchronous reset with three in flight");
      applyStimulus(16'h3F00, 16'h3F00);
      applyStimulus(16'h3E01, 16'h3F00);
      applyStimulus(16'h3E00, 16'hC000);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("mid_rst_y", 32'(y), 32'd0);
      checkOutput("mid_rst_flags", 32'(flags), 32'd0);
      checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("no_stale", 32'(out_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      applyStimulus(16'h3E01, 16'h3E01);
      measureLatency();
      waitDrain();

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
